and_gate: RTL and testbench

AND_GATE -- requirements
Module: and_gate

---
 rtl/and_gate.sv | 64 ++++++
 tb/tb_and_gate.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/and_gate.sv
// Bitwise AND with a registered, change-counting capture path.
// y/y_all/y_any are combinational; y_q/y_vld/chg_cnt are clocked.
module and_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             y_vld,
  output logic             y_all,
  output logic             y_any,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] y_q_q, y_q_d;
  logic             y_vld_q, y_vld_d;
  logic [CNT_W-1:0] chg_cnt_q, chg_cnt_d;
  logic             changed;

  always_comb begin
    y     = a & b;
    y_all = &y;
    y_any = |y;
  end

  // Only a capture over an already-valid value can count as a change.
  always_comb begin
    changed   = y_vld_q && (y != y_q_q);
    y_q_d     = y_q_q;
    y_vld_d   = y_vld_q;
    chg_cnt_d = chg_cnt_q;
    if (en) begin
      y_q_d   = y;
      y_vld_d = 1'b1;
      if (changed && (chg_cnt_q != CNT_MAX)) begin
        chg_cnt_d = chg_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q_q     <= '0;
      y_vld_q   <= 1'b0;
      chg_cnt_q <= '0;
    end else begin
      y_q_q     <= y_q_d;
      y_vld_q   <= y_vld_d;
      chg_cnt_q <= chg_cnt_d;
    end
  end

  assign y_q     = y_q_q;
  assign y_vld   = y_vld_q;
  assign chg_cnt = chg_cnt_q;

endmodule

// File: tb/tb_and_gate.sv
// Self-checking bench for and_gate: three instances cover
// WIDTH=1, WIDTH=8 and a 2-bit saturating counter.
module tb_and_gate;

  logic clk, clk_run, rst_n, en;

  logic       a1, b1, y1, yq1, v1, all1, any1;
  logic [7:0] c1;

  logic [7:0] a8, b8, y8, yq8;
  logic       v8, all8, any8;
  logic [7:0] c8;

  logic       ac, bc, yc, yqc, vc, allc, anyc;
  logic [1:0] cc;

  int n_run, n_fail;

  and_gate #(.WIDTH(1), .CNT_W(8)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .en(en),
    .y(y1), .y_q(yq1), .y_vld(v1), .y_all(all1),
    .y_any(any1), .chg_cnt(c1)
  );

  and_gate #(.WIDTH(8), .CNT_W(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .en(en),
    .y(y8), .y_q(yq8), .y_vld(v8), .y_all(all8),
    .y_any(any8), .chg_cnt(c8)
  );

  and_gate #(.WIDTH(1), .CNT_W(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .a(ac), .b(bc), .en(en),
    .y(yc), .y_q(yqc), .y_vld(vc), .y_all(allc),
    .y_any(anyc), .chg_cnt(cc)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_comb_w1();
    logic [1:0] ab;
    logic       ey;
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      a1 = ab[1];
      b1 = ab[0];
      ey = (i == 3);
      for (int k = 0; k < 2; k++) begin
        #5;
        n_run++;
        if ({y1, all1, any1} !== {ey, ey, ey}) begin
          n_fail++;
          $display("FAIL comb_w1 ab=%0d: y/all/any=%b%b%b want %b%b%b",
                   i, y1, all1, any1, ey, ey, ey);
        end
      end
    end
  endtask

  task automatic test_comb_w8();
    logic [7:0] ta [3];
    logic [7:0] tb [3];
    logic [7:0] ey [3];
    logic       eall [3];
    logic       eany [3];
    ta = '{8'hF0, 8'hFF, 8'h00};
    tb = '{8'h3C, 8'hFF, 8'hA5};
    ey = '{8'h30, 8'hFF, 8'h00};
    eall = '{1'b0, 1'b1, 1'b0};
    eany = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      a8 = ta[i];
      b8 = tb[i];
      #1;
      n_run++;
      if ({y8, all8, any8} !== {ey[i], eall[i], eany[i]}) begin
        n_fail++;
        $display("FAIL comb_w8 #%0d: y=%h all=%b any=%b want %h %b %b",
                 i, y8, all8, any8, ey[i], eall[i], eany[i]);
      end
    end
  endtask

  task automatic test_xprop();
    logic [7:0] xa, xb;
    xa = 8'b01xz_01xz;
    xb = 8'b0000_1111;
    a8 = xa;
    b8 = xb;
    #1;
    n_run++;
    if ({y8[7:2], all8, any8} !== 8'b000001_0_1) begin
      n_fail++;
      $display("FAIL xprop: y[7:2]=%b all=%b any=%b want 000001 0 1",
               y8[7:2], all8, any8);
    end
    a8 = xb;
    b8 = xa;
    #1;
    n_run++;
    if (y8[7:2] !== 6'b000001) begin
      n_fail++;
      $display("FAIL xprop_swap: y[7:2]=%b want 000001", y8[7:2]);
    end
  endtask

  task automatic test_reset();
    en = 1'b1;
    a8 = 8'hA5;
    b8 = 8'h0F;
    ac = 1'b1;
    bc = 1'b1;
    #1;
    n_run++;
    if ({yq8, v8, c8, yqc, vc, cc} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: yq8=%h v8=%b c8=%0d yqc=%b vc=%b cc=%0d",
               yq8, v8, c8, yqc, vc, cc);
    end
    n_run++;
    if (y8 !== 8'h05 || yc !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_comb: y8=%h yc=%b want 05 1", y8, yc);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_run++;
      if ({yq8, v8, c8, yqc, vc} !== '0) begin
        n_fail++;
        $display("FAIL reset_no_capture: yq8=%h v8=%b c8=%0d yqc=%b vc=%b",
                 yq8, v8, c8, yqc, vc);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_capture();
    rst_pulse();
    en = 1'b1;
    a8 = 8'h01;
    b8 = 8'h01;
    tick();
    n_run++;
    if ({yq8, v8, c8} !== {8'h01, 1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL first_capture: yq=%h v=%b cnt=%0d want 01 1 0",
               yq8, v8, c8);
    end
    a8 = 8'h00;
    tick();
    n_run++;
    if ({yq8, v8, c8} !== {8'h00, 1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL second_capture: yq=%h v=%b cnt=%0d want 00 1 1",
               yq8, v8, c8);
    end
  endtask

  task automatic test_hold();
    en = 1'b0;
    b8 = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      a8 = (i % 2 == 0) ? 8'hFF : 8'h0F;
      tick();
      n_run++;
      if ({yq8, v8, c8, y8} !== {8'h00, 1'b1, 8'd1, a8}) begin
        n_fail++;
        $display("FAIL hold #%0d: yq=%h v=%b cnt=%0d y=%h want 00 1 1 %h",
                 i, yq8, v8, c8, y8, a8);
      end
    end
  endtask

  task automatic test_saturate();
    logic m_q, m_v;
    int   m_cnt;
    rst_pulse();
    m_q = 1'b0;
    m_v = 1'b0;
    m_cnt = 0;
    en = 1'b1;
    ac = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bc = (i % 2 == 0);
      tick();
      if (m_v && (m_q != bc) && m_cnt < 3) m_cnt++;
      m_q = bc;
      m_v = 1'b1;
      n_run++;
      if ({yqc, vc, cc} !== {m_q, m_v, 2'(m_cnt)}) begin
        n_fail++;
        $display("FAIL saturate #%0d: yq=%b v=%b cnt=%0d want %b %b %0d",
                 i, yqc, vc, cc, m_q, m_v, m_cnt);
      end
    end
    n_run++;
    if (cc !== 2'd3) begin
      n_fail++;
      $display("FAIL saturate_final: cnt=%0d want 3", cc);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    #2;
    ac = 1'b1;
    bc = 1'b0;
    rst_n = 1'b0;
    #1;
    n_run++;
    if ({yqc, vc, cc, yc} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_mid: yq=%b v=%b cnt=%0d y=%b want 0 0 0 0",
               yqc, vc, cc, yc);
    end
    bc = 1'b1;
    #1;
    n_run++;
    if ({yc, allc, anyc} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_mid_comb: y/all/any=%b%b%b want 111",
               yc, allc, anyc);
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    bc = 1'b0;
    tick();
    bc = 1'b1;
    tick();
    n_run++;
    if ({yqc, vc, cc} !== {1'b1, 1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL reset_restart: yq=%b v=%b cnt=%0d want 1 1 1",
               yqc, vc, cc);
    end
  endtask

  task automatic test_random();
    logic [7:0] m_q, ey;
    logic       m_v;
    int         m_cnt;
    rst_pulse();
    m_q = '0;
    m_v = 1'b0;
    m_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0, 1:    ;
        2:       begin a8 = 8'hFF; b8 = 8'hFF; end
        default: begin a8 = 8'($urandom); b8 = 8'($urandom); end
      endcase
      ey = a8 & b8;
      #1;
      n_run++;
      if ({y8, all8, any8} !== {ey, ey == 8'hFF, ey != 8'h00}) begin
        n_fail++;
        $display("FAIL rand_comb #%0d: y=%h all=%b any=%b want %h",
                 i, y8, all8, any8, ey);
      end
      @(posedge clk);
      if (en) begin
        if (m_v && ey != m_q && m_cnt < 255) m_cnt++;
        m_q = ey;
        m_v = 1'b1;
      end
      #1;
      n_run++;
      if ({yq8, v8, c8} !== {m_q, m_v, 8'(m_cnt)}) begin
        n_fail++;
        $display("FAIL rand_reg #%0d: yq=%h v=%b cnt=%0d want %h %b %0d",
                 i, yq8, v8, c8, m_q, m_v, m_cnt);
      end
    end
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    clk_run = 1'b0;
    rst_n = 1'b0;
    en = 1'b0;
    a1 = 1'b0;
    b1 = 1'b0;
    a8 = '0;
    b8 = '0;
    ac = 1'b0;
    bc = 1'b0;
    test_comb_w1();
    test_comb_w8();
    test_xprop();
    clk_run = 1'b1;
    test_reset();
    test_first_capture();
    test_hold();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
